logica_push_vc: RTL and testbench
=================================

# logica_push_vc

Ingress writer for the transmission-layer virtual-channel FIFOs. Accepts a stream of 6-bit words from upstream, classifies each by its VC-select bit, and pushes it into the VC0 or VC1 FIFO. It obeys those FIFOs' full/almost-full backpressure through a 2-entry in-order holding buffer and a ready signal upstream. It is the write-side counterpart of the arbiter pop logic that drains VC0/VC1.

## Interface
Parameters:
- DATA_W, 6, word width.
- VC_SEL_BIT, 4, bit index selecting the target VC (0 = VC0, 1 = VC1).

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DATA_W  upstream word.
- valid_in  in  1  data_in valid.
- ready_out  out  1  block can accept a word this cycle.
- VC0_full, VC0_almost_full  in  1  VC0 FIFO status.
- VC1_full, VC1_almost_full  in  1  VC1 FIFO status.
- VC0_push, VC1_push  out  1  registered push strobes, one cycle each.
- data_VC0, data_VC1  out  DATA_W  registered write data, valid with the matching push.
- push_delay_VC0, push_delay_VC1  out  1  push strobes delayed one cycle.
- cnt_VC0, cnt_VC1  out  8  push counters; present only with PUSH_COUNT_EN.

## Operation
- Pause rules: pause_VC0 = VC0_full | VC0_almost_full. pause_VC1 is the same function of the VC1 status bits.
- Accept: a word is accepted when valid_in & ready_out at a posedge.
- ready_out = ~reset & (occupancy != 2). It is a combinational function of registered occupancy only.
- Occupancy FSM: EMPTY (0), ONE (1), TWO (2). Per edge, occupancy_next = occupancy + accept − drain.
- Drain: a drain happens at an edge when occupancy > 0 and the head word's target is not paused.
  - The head word moves to the data_VCx output register and VCx_push is set for that cycle.
- Bypass: when occupancy is EMPTY and the accepted word's target is not paused, the word goes straight to the output register. It is not enqueued.
- Otherwise the accepted word is enqueued behind existing entries.
- Ordering is strict across both VCs. A paused head blocks later words even if they target the other VC.
- At most one push per cycle; VC0_push and VC1_push are never high together.
- data_VCx holds its last value when its push is low.
- Reset, including mid-operation: discards buffer contents. All outputs are 0 (ready_out, pushes, push_delays, data, counters), and occupancy is EMPTY.

## Timing
- Latency, bypass path: word accepted at edge k gives VCx_push high in cycle k..k+1.
- Latency, buffered path: a word enqueued at edge k can drain no earlier than edge k+1.
- Pause is sampled at the drain edge. A push already registered still completes, so the FIFO almost_full threshold must absorb 1 in-flight word.
- Accept and drain at the same edge are allowed in ONE, where occupancy stays 1.
- In TWO, ready_out is low. A drain at edge k lets ready_out rise in cycle k..k+1.
- push_delay_VCx(k+1) = VCx_push(k).
- Counters are 8-bit and wrap 255 -> 0. They increment at the edge that registers each push.

## Configuration
- PUSH_COUNT_EN defined: cnt_VC0 and cnt_VC1 ports and their registers exist, behaving as specified above.
- PUSH_COUNT_EN undefined: the ports and registers are removed. All other behaviour is identical.

## Structure
- Shared package logica_pkg holds:
  - DATA_W and VC_SEL_BIT defaults;
  - the occupancy enum (OCC_EMPTY, OCC_ONE, OCC_TWO);
  - the counter width constant (8).
- Sub-module skid_fifo_2: 2-entry in-order buffer with push, pop, head, and occupancy.
- The top level holds the classification, pause logic, bypass, output registers, delay registers, and counters.

## Test plan
- Reset, then data_in=6'h05, valid_in=1, no pauses: VC0_push=1 with data_VC0=6'h05 one cycle later, push_delay_VC0=1 the cycle after, ready_out stays 1.
- Word 6'h15 (bit4=1) with VC1_almost_full=1 for 3 cycles: buffered, no push. Releasing the pause gives VC1_push with data 6'h15 one edge later.
- VC0 paused, then words 6'h01, 6'h12, 6'h03 back-to-back:
  - 01 and 12 are buffered and ready_out drops;
  - 03 is held upstream;
  - 12 does not pass 01 (head-of-line);
  - after the release, the push order is 01, 12, 03.
- Reset asserted while occupancy=2: the next cycle has occupancy EMPTY, all outputs 0, and the buffered words are never pushed.
- With PUSH_COUNT_EN, 257 VC0 words: cnt_VC0=1 and cnt_VC1=0.

Source files
------------

// File: rtl/logica_pkg.sv
// Shared constants and types for the VC push (ingress writer) logic.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package logica_pkg;

  // Default word width and the bit that selects the target VC.
  localparam int DATA_W_DEF     = 6;
  localparam int VC_SEL_BIT_DEF = 4;

  // Width of the optional per-VC push counters (wrap at 2**CNT_W).
  localparam int CNT_W = 8;

  // Holding-buffer occupancy; encoding equals the entry count.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/skid_fifo_2.sv
// Two-entry in-order holding buffer; entry 0 is always the head.
// Latency: a word pushed at edge k is visible on head_dat from cycle k..k+1.
// Backpressure: caller must not push when occ is TWO; pop on empty is ignored.
module skid_fifo_2
  import logica_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic [DATA_W-1:0] head_dat,
  output logic [1:0]        occ
);

  occ_e              occ_q, occ_d;
  logic [DATA_W-1:0] ent0_q, ent0_d;
  logic [DATA_W-1:0] ent1_q, ent1_d;

  // Occupancy state machine and entry shifting: pop moves entry 1 to the head.
  always_comb begin
    occ_d  = occ_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          ent0_d = push_dat;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        case ({push, pop})
          2'b10: begin
            ent1_d = push_dat;
            occ_d  = OCC_TWO;
          end
          2'b01: occ_d = OCC_EMPTY;
          2'b11: ent0_d = push_dat;  // head leaves, new word becomes head
          default: ;
        endcase
      end
      OCC_TWO: begin
        if (pop) begin
          ent0_d = ent1_q;
          if (push) begin
            ent1_d = push_dat;
          end else begin
            occ_d = OCC_ONE;
          end
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  // State registers; reset discards any buffered words.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q  <= OCC_EMPTY;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      occ_q  <= occ_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end

  assign head_dat = ent0_q;
  assign occ      = occ_q;

endmodule

// File: rtl/logica_push_vc.sv
// Ingress writer: classifies words by VC-select bit and pushes them into VC0/VC1 FIFOs.
// Latency: bypass word accepted at edge k pushes in cycle k..k+1; buffered words drain from edge k+1.
// Backpressure: 2-entry in-order buffer, ready_out low when full; optional counters via PUSH_COUNT_EN.
module logica_push_vc
  import logica_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int VC_SEL_BIT = VC_SEL_BIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic              VC0_full,
  input  logic              VC0_almost_full,
  input  logic              VC1_full,
  input  logic              VC1_almost_full,
  output logic              VC0_push,
  output logic              VC1_push,
  output logic [DATA_W-1:0] data_VC0,
  output logic [DATA_W-1:0] data_VC1,
  output logic              push_delay_VC0,
  output logic              push_delay_VC1
`ifdef PUSH_COUNT_EN
  ,
  output logic [CNT_W-1:0]  cnt_VC0,
  output logic [CNT_W-1:0]  cnt_VC1
`endif
);

  logic [DATA_W-1:0] head_dat;
  logic [1:0]        occ;

  logic pause_vc0, pause_vc1;
  logic occ_empty;
  logic accept, drain, bypass, enqueue;
  logic head_vc, in_vc, head_paused, in_paused;

  logic              vc0_push_q, vc0_push_d;
  logic              vc1_push_q, vc1_push_d;
  logic [DATA_W-1:0] data_vc0_q, data_vc0_d;
  logic [DATA_W-1:0] data_vc1_q, data_vc1_d;
  logic              push_dly_vc0_q, push_dly_vc0_d;
  logic              push_dly_vc1_q, push_dly_vc1_d;

  skid_fifo_2 #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (enqueue),
    .push_dat (data_in),
    .pop      (drain),
    .head_dat (head_dat),
    .occ      (occ)
  );

  // Ready depends only on registered occupancy (and reset), never on the FIFO status.
  assign ready_out = ~reset & (occ != OCC_TWO);

  // Classification, pause, and the accept/drain/bypass decisions for this edge.
  always_comb begin
    pause_vc0   = VC0_full | VC0_almost_full;
    pause_vc1   = VC1_full | VC1_almost_full;
    occ_empty   = (occ == OCC_EMPTY);
    head_vc     = head_dat[VC_SEL_BIT];
    in_vc       = data_in[VC_SEL_BIT];
    head_paused = head_vc ? pause_vc1 : pause_vc0;
    in_paused   = in_vc ? pause_vc1 : pause_vc0;
    accept      = valid_in & ready_out;
    // A paused head blocks everything behind it, whichever VC they target.
    drain       = ~occ_empty & ~head_paused;
    // Bypass only when nothing is queued, so ordering is never violated.
    bypass      = accept & occ_empty & ~in_paused;
    enqueue     = accept & ~bypass;
  end

  // Output register next-state: drain and bypass are mutually exclusive (occupancy).
  always_comb begin
    vc0_push_d     = 1'b0;
    vc1_push_d     = 1'b0;
    data_vc0_d     = data_vc0_q;
    data_vc1_d     = data_vc1_q;
    push_dly_vc0_d = vc0_push_q;
    push_dly_vc1_d = vc1_push_q;
    if (drain) begin
      if (head_vc) begin
        vc1_push_d = 1'b1;
        data_vc1_d = head_dat;
      end else begin
        vc0_push_d = 1'b1;
        data_vc0_d = head_dat;
      end
    end else if (bypass) begin
      if (in_vc) begin
        vc1_push_d = 1'b1;
        data_vc1_d = data_in;
      end else begin
        vc0_push_d = 1'b1;
        data_vc0_d = data_in;
      end
    end
  end

  // Registered push strobes, write data and one-cycle delayed strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      vc0_push_q     <= 1'b0;
      vc1_push_q     <= 1'b0;
      data_vc0_q     <= '0;
      data_vc1_q     <= '0;
      push_dly_vc0_q <= 1'b0;
      push_dly_vc1_q <= 1'b0;
    end else begin
      vc0_push_q     <= vc0_push_d;
      vc1_push_q     <= vc1_push_d;
      data_vc0_q     <= data_vc0_d;
      data_vc1_q     <= data_vc1_d;
      push_dly_vc0_q <= push_dly_vc0_d;
      push_dly_vc1_q <= push_dly_vc1_d;
    end
  end

  assign VC0_push       = vc0_push_q;
  assign VC1_push       = vc1_push_q;
  assign data_VC0       = data_vc0_q;
  assign data_VC1       = data_vc1_q;
  assign push_delay_VC0 = push_dly_vc0_q;
  assign push_delay_VC1 = push_dly_vc1_q;

`ifdef PUSH_COUNT_EN
  logic [CNT_W-1:0] cnt_vc0_q, cnt_vc0_d;
  logic [CNT_W-1:0] cnt_vc1_q, cnt_vc1_d;

  // Counters step at the same edge that registers the push; natural wrap at 255.
  always_comb begin
    cnt_vc0_d = cnt_vc0_q + {{(CNT_W-1){1'b0}}, vc0_push_d};
    cnt_vc1_d = cnt_vc1_q + {{(CNT_W-1){1'b0}}, vc1_push_d};
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_vc0_q <= '0;
      cnt_vc1_q <= '0;
    end else begin
      cnt_vc0_q <= cnt_vc0_d;
      cnt_vc1_q <= cnt_vc1_d;
    end
  end

  assign cnt_VC0 = cnt_vc0_q;
  assign cnt_VC1 = cnt_vc1_q;
`endif

endmodule

// File: tb/tb_logica_push_vc.sv
// Directed bench for logica_push_vc: bypass, pause buffering, ordering, reset, counters.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: stimulus holds words upstream while ready_out is low.
module tb_logica_push_vc;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       VC0_full, VC0_almost_full, VC1_full, VC1_almost_full;
  logic       VC0_push, VC1_push;
  logic [5:0] data_VC0, data_VC1;
  logic       push_delay_VC0, push_delay_VC1;
`ifdef PUSH_COUNT_EN
  logic [7:0] cnt_VC0, cnt_VC1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logica_push_vc dut (
    .clk             (clk),
    .reset           (reset),
    .data_in         (data_in),
    .valid_in        (valid_in),
    .ready_out       (ready_out),
    .VC0_full        (VC0_full),
    .VC0_almost_full (VC0_almost_full),
    .VC1_full        (VC1_full),
    .VC1_almost_full (VC1_almost_full),
    .VC0_push        (VC0_push),
    .VC1_push        (VC1_push),
    .data_VC0        (data_VC0),
    .data_VC1        (data_VC1),
    .push_delay_VC0  (push_delay_VC0),
    .push_delay_VC1  (push_delay_VC1)
`ifdef PUSH_COUNT_EN
    ,
    .cnt_VC0         (cnt_VC0),
    .cnt_VC1         (cnt_VC1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b0; data_in = 6'h00;
    VC0_full = 1'b0; VC0_almost_full = 1'b0; VC1_full = 1'b0; VC1_almost_full = 1'b0;
    tick(); tick();
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", ready_out); end
    total++; if ({VC0_push, VC1_push} !== 2'b00) begin bad++; $display("FAIL rst_push got=%b exp=00", {VC0_push, VC1_push}); end
    total++; if ({data_VC0, data_VC1} !== 12'h000) begin bad++; $display("FAIL rst_data got=%h exp=000", {data_VC0, data_VC1}); end
    total++; if ({push_delay_VC0, push_delay_VC1} !== 2'b00) begin bad++; $display("FAIL rst_pdly got=%b exp=00", {push_delay_VC0, push_delay_VC1}); end
    reset = 1'b0;
    #1;
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", ready_out); end
  endtask

  task automatic test_bypass();
    data_in = 6'h05; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    total++; if (VC0_push !== 1'b1 || VC1_push !== 1'b0) begin bad++; $display("FAIL byp_push got=%b%b exp=10", VC0_push, VC1_push); end
    total++; if (data_VC0 !== 6'h05) begin bad++; $display("FAIL byp_data got=%h exp=05", data_VC0); end
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL byp_ready got=%b exp=1", ready_out); end
    tick();
    total++; if (VC0_push !== 1'b0 || push_delay_VC0 !== 1'b1) begin bad++; $display("FAIL byp_delay got=%b%b exp=01", VC0_push, push_delay_VC0); end
    total++; if (data_VC0 !== 6'h05) begin bad++; $display("FAIL byp_hold got=%h exp=05", data_VC0); end
    tick();
    total++; if (push_delay_VC0 !== 1'b0) begin bad++; $display("FAIL byp_delay_clr got=%b exp=0", push_delay_VC0); end
    // VC1 word bypasses while VC0 is paused: the queue is empty so nothing blocks it.
    VC0_full = 1'b1; data_in = 6'h1A; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; VC0_full = 1'b0;
    total++; if (VC1_push !== 1'b1 || data_VC1 !== 6'h1A || VC0_push !== 1'b0) begin bad++; $display("FAIL byp_vc1 got=%b%b/%h exp=01/1a", VC0_push, VC1_push, data_VC1); end
    tick();
  endtask

  task automatic test_pause_vc1();
    VC1_almost_full = 1'b1; data_in = 6'h15; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    total++; if (VC1_push !== 1'b0 || ready_out !== 1'b1) begin bad++; $display("FAIL p1_buffered got=%b%b exp=01", VC1_push, ready_out); end
    tick(); tick();
    total++; if (VC1_push !== 1'b0 || data_VC1 !== 6'h1A) begin bad++; $display("FAIL p1_held got=%b/%h exp=0/1a", VC1_push, data_VC1); end
    VC1_almost_full = 1'b0;
    tick();
    total++; if (VC1_push !== 1'b1 || data_VC1 !== 6'h15) begin bad++; $display("FAIL p1_release got=%b/%h exp=1/15", VC1_push, data_VC1); end
    tick();
    total++; if (VC1_push !== 1'b0 || push_delay_VC1 !== 1'b1) begin bad++; $display("FAIL p1_after got=%b%b exp=01", VC1_push, push_delay_VC1); end
  endtask

  task automatic test_head_of_line();
    VC0_full = 1'b1; data_in = 6'h01; valid_in = 1'b1;
    tick();
    total++; if (ready_out !== 1'b1 || VC0_push !== 1'b0) begin bad++; $display("FAIL hol_first got=%b%b exp=10", ready_out, VC0_push); end
    data_in = 6'h12;
    tick();
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL hol_full_ready got=%b exp=0", ready_out); end
    total++; if (VC1_push !== 1'b0) begin bad++; $display("FAIL hol_no_pass got=%b exp=0", VC1_push); end
    data_in = 6'h03;
    tick();
    total++; if ({VC0_push, VC1_push, ready_out} !== 3'b000) begin bad++; $display("FAIL hol_stall got=%b exp=000", {VC0_push, VC1_push, ready_out}); end
    VC0_full = 1'b0;
    tick();
    total++; if (VC0_push !== 1'b1 || data_VC0 !== 6'h01 || VC1_push !== 1'b0) begin bad++; $display("FAIL hol_ord0 got=%b/%h exp=1/01", VC0_push, data_VC0); end
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL hol_ready_rise got=%b exp=1", ready_out); end
    tick();
    valid_in = 1'b0;
    total++; if (VC1_push !== 1'b1 || data_VC1 !== 6'h12 || VC0_push !== 1'b0) begin bad++; $display("FAIL hol_ord1 got=%b/%h exp=1/12", VC1_push, data_VC1); end
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL hol_one_stays got=%b exp=1", ready_out); end
    tick();
    total++; if (VC0_push !== 1'b1 || data_VC0 !== 6'h03 || VC1_push !== 1'b0) begin bad++; $display("FAIL hol_ord2 got=%b/%h exp=1/03", VC0_push, data_VC0); end
    tick();
    total++; if (VC0_push !== 1'b0 || push_delay_VC0 !== 1'b1) begin bad++; $display("FAIL hol_idle got=%b%b exp=01", VC0_push, push_delay_VC0); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] words [4];
    words[0] = 6'h07; words[1] = 6'h17; words[2] = 6'h08; words[3] = 6'h18;
    valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = words[i];
      tick();
      if (words[i][4]) begin
        total++; if (VC1_push !== 1'b1 || VC0_push !== 1'b0 || data_VC1 !== words[i]) begin bad++; $display("FAIL b2b_%0d got=%b%b/%h exp=01/%h", i, VC0_push, VC1_push, data_VC1, words[i]); end
      end else begin
        total++; if (VC0_push !== 1'b1 || VC1_push !== 1'b0 || data_VC0 !== words[i]) begin bad++; $display("FAIL b2b_%0d got=%b%b/%h exp=10/%h", i, VC0_push, VC1_push, data_VC0, words[i]); end
      end
    end
    valid_in = 1'b0;
    tick();
    total++; if (push_delay_VC1 !== 1'b1 || push_delay_VC0 !== 1'b0) begin bad++; $display("FAIL b2b_delay got=%b%b exp=01", push_delay_VC0, push_delay_VC1); end
  endtask

  task automatic test_reset_mid();
    int pushes;
    VC0_full = 1'b1; valid_in = 1'b1; data_in = 6'h21;
    tick();
    data_in = 6'h22;
    tick();
    valid_in = 1'b0;
    total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL rmid_full got=%b exp=0", ready_out); end
    reset = 1'b1;
    tick();
    total++; if ({ready_out, VC0_push, VC1_push, push_delay_VC0, push_delay_VC1} !== 5'b0) begin bad++; $display("FAIL rmid_ctl got=%b exp=00000", {ready_out, VC0_push, VC1_push, push_delay_VC0, push_delay_VC1}); end
    total++; if ({data_VC0, data_VC1} !== 12'h000) begin bad++; $display("FAIL rmid_data got=%h exp=000", {data_VC0, data_VC1}); end
    reset = 1'b0; VC0_full = 1'b0;
    #1;
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL rmid_empty got=%b exp=1", ready_out); end
    pushes = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pushes += int'(VC0_push) + int'(VC1_push);
    end
    total++; if (pushes !== 0 || data_VC0 !== 6'h00) begin bad++; $display("FAIL rmid_discard pushes=%0d data=%h exp=0/00", pushes, data_VC0); end
  endtask

`ifdef PUSH_COUNT_EN
  task automatic test_counters();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (cnt_VC0 !== 8'd0 || cnt_VC1 !== 8'd0) begin bad++; $display("FAIL cnt_rst got=%0d/%0d exp=0/0", cnt_VC0, cnt_VC1); end
    data_in = 6'h01; valid_in = 1'b1;
    for (int i = 1; i <= 257; i++) begin
      tick();
      if (i == 255) begin
        total++; if (cnt_VC0 !== 8'd255) begin bad++; $display("FAIL cnt_255 got=%0d exp=255", cnt_VC0); end
      end
    end
    valid_in = 1'b0;
    tick();
    total++; if (cnt_VC0 !== 8'd1 || cnt_VC1 !== 8'd0) begin bad++; $display("FAIL cnt_wrap got=%0d/%0d exp=1/0", cnt_VC0, cnt_VC1); end
  endtask
`endif

  initial begin
    test_reset();
    test_bypass();
    test_pause_vc1();
    test_head_of_line();
    test_back_to_back();
    test_reset_mid();
`ifdef PUSH_COUNT_EN
    test_counters();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
